max_finder: RTL and testbench

Output-classification stage placed directly downstream of the last neural layer in `NNConnect`. It accepts the full vector of final-layer neuron outputs in one beat and scans it serially with one signed comparison per cycle. It then publishes the index of the largest output as the detected class on `rdata`, raising `intr` to signal that a result is ready.

---
 rtl/nn_pkg.sv | 28 ++
 rtl/max_finder.sv | 141 ++++++++++++++
 tb/tb_max_finder.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/nn_pkg.sv
// Shared constants and types for the NNConnect classification stage.
// Holds the default neuron-output width, the class count, the max_finder
// state encoding and the class-index type used by downstream logic.
package nn_pkg;

    // Width of one final-layer neuron output (two's-complement fixed point)
    localparam int DATA_WIDTH  = 16;

    // Number of final-layer neurons, i.e. number of output classes
    localparam int NUM_CLASSES = 10;

    // Index width for a vector of n elements; never narrower than one bit so
    // a single-class build still has a legal counter/index register.
    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Scan controller states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } maxf_state_t;

    // Class index for the default network size
    typedef logic [idx_width(NUM_CLASSES)-1:0] class_idx_t;

endpackage : nn_pkg

// File: rtl/max_finder.sv
// max_finder: serial argmax over the final-layer neuron outputs.
// A whole vector is captured in one beat, then scanned one signed compare per
// cycle; the index of the largest element (lowest index on ties) is published
// on rdata with a one-cycle out_valid pulse and a sticky intr level.
// Optional feature macro: MAXFINDER_SCORE_EN -- when defined, out_score carries
// the winning value; otherwise out_score is tied to zero.
module max_finder #(
    parameter int NUM_INPUTS = nn_pkg::NUM_CLASSES,
    parameter int DATA_WIDTH = nn_pkg::DATA_WIDTH
) (
    input  logic                             aclk,
    input  logic                             areset,
    input  logic [NUM_INPUTS*DATA_WIDTH-1:0] in_data,
    input  logic                             in_data_valid,
    output logic                             in_ready,
    output logic [31:0]                      rdata,
    output logic                             out_valid,
    output logic                             intr,
    output logic [DATA_WIDTH-1:0]            out_score
);
    import nn_pkg::*;

    // Index/counter width and the last index the scan visits
    localparam int             IW       = idx_width(NUM_INPUTS);
    localparam logic [IW-1:0]  LAST_IDX = IW'(NUM_INPUTS - 1);

    // Captured copy of the input vector, one signed element per entry
    logic signed [DATA_WIDTH-1:0] r_elem [NUM_INPUTS];

    // Scan state
    maxf_state_t                  r_state;
    logic [IW-1:0]                r_cnt;
    logic [IW-1:0]                r_max_idx;
    logic signed [DATA_WIDTH-1:0] r_max_val;

    // Registered outputs
    logic                         r_in_ready;
    logic [31:0]                  r_rdata;
    logic                         r_out_valid;
    logic                         r_intr;

    // Element currently under comparison and the strict greater-than result;
    // strictness is what makes the lowest index win among equal maxima.
    logic signed [DATA_WIDTH-1:0] w_cur_elem;
    logic                         w_greater;
    logic                         w_accept;

    assign w_cur_elem = r_elem[r_cnt];
    assign w_greater  = (w_cur_elem > r_max_val);
    assign w_accept   = in_data_valid && (r_state == IDLE);

    // Capture the full vector only on acceptance; a beat offered while busy
    // leaves the stored vector untouched. Data path needs no reset.
    always_ff @(posedge aclk) begin
        if (w_accept) begin
            for (int i = 0; i < NUM_INPUTS; i++) begin
                r_elem[i] <= in_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Control FSM: accept -> scan one element per cycle -> publish -> idle
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_max_idx   <= '0;
            r_max_val   <= '0;
            r_in_ready  <= 1'b1;
            r_rdata     <= '0;
            r_out_valid <= 1'b0;
            r_intr      <= 1'b0;
        end else begin
            // out_valid is a single-cycle pulse; only DONE raises it
            r_out_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (in_data_valid) begin
                        // Element 0 seeds the running maximum, scan resumes at 1
                        r_max_val  <= in_data[0 +: DATA_WIDTH];
                        r_max_idx  <= '0;
                        r_cnt      <= IW'(1);
                        r_intr     <= 1'b0;
                        r_in_ready <= 1'b0;
                        if (NUM_INPUTS == 1) begin
                            r_state <= DONE;
                        end else begin
                            r_state <= SCAN;
                        end
                    end
                end
                SCAN: begin
                    if (w_greater) begin
                        r_max_val <= w_cur_elem;
                        r_max_idx <= r_cnt;
                    end
                    r_cnt <= r_cnt + IW'(1);
                    // Exit on the last element rather than relying on wrap
                    if (r_cnt == LAST_IDX) begin
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_rdata     <= 32'(r_max_idx);
                    r_out_valid <= 1'b1;
                    r_intr      <= 1'b1;
                    r_in_ready  <= 1'b1;
                    r_state     <= IDLE;
                end
                default: begin
                    r_state    <= IDLE;
                    r_in_ready <= 1'b1;
                end
            endcase
        end
    end

`ifdef MAXFINDER_SCORE_EN
    logic [DATA_WIDTH-1:0] r_score;

    // Winning value published alongside the index on the DONE edge
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_score <= '0;
        end else if (r_state == DONE) begin
            r_score <= r_max_val;
        end
    end

    assign out_score = r_score;
`else
    // Score register not built; port kept so both builds share one port list
    assign out_score = '0;
`endif

    assign in_ready  = r_in_ready;
    assign rdata     = r_rdata;
    assign out_valid = r_out_valid;
    assign intr      = r_intr;

endmodule : max_finder

// File: tb/tb_max_finder.sv
// Testbench for max_finder: table-driven vectors plus hand-written corner
// sequences, checked through an expected-result scoreboard.
module tb_max_finder;

    localparam int N  = 10;
    localparam int DW = 16;

    logic            aclk = 1'b0;
    logic            areset = 1'b1;
    logic [N*DW-1:0] in_data = '0;
    logic            in_data_valid = 1'b0;
    logic            in_ready;
    logic [31:0]     rdata;
    logic            out_valid;
    logic            intr;
    logic [DW-1:0]   out_score;

    always #5 aclk = ~aclk;

    max_finder #(
        .NUM_INPUTS (N),
        .DATA_WIDTH (DW)
    ) dut (
        .aclk          (aclk),
        .areset        (areset),
        .in_data       (in_data),
        .in_data_valid (in_data_valid),
        .in_ready      (in_ready),
        .rdata         (rdata),
        .out_valid     (out_valid),
        .intr          (intr),
        .out_score     (out_score)
    );

    typedef struct {
        int            idx;
        logic [DW-1:0] score;
        int            cyc;
    } exp_t;

    typedef struct {
        logic [DW-1:0] e [N];
        int            exp_idx;
        logic [DW-1:0] exp_score;
    } tv_t;

    exp_t sb[$];
    tv_t  tv [6];

    int   n_vec   = 0;
    int   n_err   = 0;
    int   cyc     = 0;
    int   n_pulse = 0;
    int   n_rise  = 0;
    logic prev_intr = 1'b0;

    always @(posedge aclk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end else begin
            $display("ok   %s: %0d", nm, act);
        end
    endtask

    // Reference argmax: strict signed compare, lowest index wins ties
    function automatic int ref_argmax(input logic [N*DW-1:0] v);
        int best = 0;
        for (int i = 1; i < N; i++) begin
            if ($signed(v[i*DW +: DW]) > $signed(v[best*DW +: DW])) best = i;
        end
        return best;
    endfunction

    function automatic logic [N*DW-1:0] pack(input logic [DW-1:0] e [N]);
        logic [N*DW-1:0] v;
        for (int i = 0; i < N; i++) v[i*DW +: DW] = e[i];
        return v;
    endfunction

    // Output monitor: pops the scoreboard on every out_valid pulse
    always @(negedge aclk) begin
        exp_t x;
        if (!areset) begin
            if (intr && !prev_intr) n_rise++;
            if (out_valid) begin
                n_pulse++;
                if (sb.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_out_valid: got pulse at cycle %0d, expected none (rdata %0d)", cyc, rdata);
                end else begin
                    x = sb.pop_front();
                    check("rdata", rdata, 64'(x.idx));
                    check("intr_with_result", intr, 1);
                    check("latency_cycle", cyc, 64'(x.cyc));
`ifdef MAXFINDER_SCORE_EN
                    check("out_score", out_score, x.score);
`else
                    check("out_score_tied", out_score, 0);
`endif
                end
            end
        end
        prev_intr = intr;
    end

    // Offer one vector when in_ready; optionally record the expected result
    task automatic send(input logic [N*DW-1:0] v, input bit push,
                        input int exp_idx, input logic [DW-1:0] exp_score);
        int t = 0;
        exp_t x;
        @(negedge aclk);
        while (!in_ready && t < 200) begin
            @(negedge aclk);
            t++;
        end
        if (!in_ready) begin
            n_vec++;
            n_err++;
            $display("FAIL send_timeout: in_ready got 0, expected 1");
        end
        in_data = v;
        in_data_valid = 1'b1;
        if (push) begin
            x.idx   = exp_idx;
            x.score = exp_score;
            x.cyc   = cyc + 1 + N;
            sb.push_back(x);
        end
        @(posedge aclk);
        #1;
        in_data_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int t = 0;
        while (sb.size() != 0 && t < 100) begin
            @(negedge aclk);
            t++;
        end
        if (sb.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain_timeout: pending got %0d, expected 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [N*DW-1:0] v;
        logic [N*DW-1:0] vb;
        int              p0;
        int              r0;
        int              bi;

        // Vector table
        for (int k = 0; k < 6; k++) for (int i = 0; i < N; i++) tv[k].e[i] = '0;
        for (int i = 0; i < N; i++) tv[0].e[i] = DW'(i * 100);
        tv[0].exp_idx = 9; tv[0].exp_score = 16'd900;
        for (int i = 0; i < N; i++) tv[1].e[i] = 16'hFE0C;     // -500
        tv[1].e[3] = 16'hFFFE;
        tv[1].exp_idx = 3; tv[1].exp_score = 16'hFFFE;
        tv[2].e[2] = 16'h0400; tv[2].e[7] = 16'h0400;
        tv[2].exp_idx = 2; tv[2].exp_score = 16'h0400;
        tv[3].exp_idx = 0; tv[3].exp_score = 16'h0000;
        for (int i = 0; i < N; i++) tv[4].e[i] = 16'h8000;
        tv[4].e[4] = 16'h0001;
        tv[4].exp_idx = 4; tv[4].exp_score = 16'h0001;
        for (int i = 0; i < N; i++) tv[5].e[i] = 16'd3;
        tv[5].e[0] = 16'd7; tv[5].e[5] = 16'd7;
        tv[5].exp_idx = 0; tv[5].exp_score = 16'd7;

        // Reset state
        repeat (2) @(negedge aclk);
        check("reset_rdata", rdata, 0);
        check("reset_out_valid", out_valid, 0);
        check("reset_intr", intr, 0);
        check("reset_out_score", out_score, 0);
        @(posedge aclk);
        #1 areset = 1'b0;
        @(negedge aclk);
        check("reset_in_ready", in_ready, 1);

        // Table vectors
        for (int k = 0; k < 6; k++) begin
            send(pack(tv[k].e), 1'b1, tv[k].exp_idx, tv[k].exp_score);
            @(negedge aclk);
            check("in_ready_busy", in_ready, 0);
            check("intr_cleared_on_accept", intr, 0);
            wait_drain();
            @(negedge aclk);
            check("intr_held", intr, 1);
            check("in_ready_after_done", in_ready, 1);
            check("rdata_held", rdata, 64'(tv[k].exp_idx));
        end

        // Busy drop: second vector offered mid-scan is ignored
        v = '0;  v[1*DW +: DW] = 16'd1000;
        vb = '0; vb[5*DW +: DW] = 16'd2000;
        p0 = n_pulse;
        send(v, 1'b1, 1, 16'd1000);
        repeat (2) @(posedge aclk);
        #1;
        in_data = vb;
        in_data_valid = 1'b1;
        @(posedge aclk);
        #1 in_data_valid = 1'b0;
        wait_drain();
        repeat (15) @(negedge aclk);
        check("busy_rdata", rdata, 1);
        check("busy_intr_held", intr, 1);
        check("busy_pulse_count", n_pulse - p0, 1);

        // Reset mid-scan aborts without a result
        v = '0; v[6*DW +: DW] = 16'd77;
        p0 = n_pulse;
        send(v, 1'b0, 0, '0);
        repeat (3) @(posedge aclk);
        #1 areset = 1'b1;
        @(negedge aclk);
        check("midrst_rdata", rdata, 0);
        check("midrst_intr", intr, 0);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_out_score", out_score, 0);
        repeat (2) @(posedge aclk);
        #1 areset = 1'b0;
        @(negedge aclk);
        check("midrst_in_ready", in_ready, 1);
        repeat (15) @(negedge aclk);
        check("midrst_no_pulse", n_pulse - p0, 0);
        v = '0; v[8*DW +: DW] = 16'd300; v[2*DW +: DW] = 16'd299;
        send(v, 1'b1, 8, 16'd300);
        wait_drain();

        // Back-to-back at the minimum accept interval
        r0 = n_rise;
        for (int k = 0; k < 30; k++) begin
            for (int i = 0; i < N; i++) begin
                if (k % 3 == 0) v[i*DW +: DW] = DW'($urandom_range(0, 7)) - DW'(4);
                else            v[i*DW +: DW] = DW'($urandom);
            end
            bi = ref_argmax(v);
            send(v, 1'b1, bi, v[bi*DW +: DW]);
        end
        wait_drain();
        @(negedge aclk);
        check("b2b_intr_rises", n_rise - r0, 30);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_max_finder
